// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared memory and mem_arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req/operands until their ready pulse; memory answers with mem_ack.
// Ports: fetch side (if_*), data side (d_*), memory side (mem_*), status (busy).
// Modports: slave = arbiter view, master = requester/memory-model view.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      output if_ready, if_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
      input  if_ready, if_rdata, d_ready, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch and a data requester.
// Latency: request sampled at edge N -> mem_req at N+1; ready is combinational with mem_ack.
// Backpressure: access held on the memory bus until mem_ack; new request sampled the edge after ready.
// Ports: clk, rst_n (async active-low); bus (mem_arbiter_if.slave) carries all request/memory signals.
// Optional: define MEM_ARB_FAIR_EN to grant fetch after two consecutive data grants made while fetch waited;
// without it data has strict priority.
module mem_arbiter (
   input  logic              clk,
   input  logic              rst_n,
   mem_arbiter_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_D = 2'd1,
      SERVE_I = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        grant_d;

`ifdef MEM_ARB_FAIR_EN
   logic [1:0]  fair_cnt_q, fair_cnt_d;
`endif

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      grant_d     = bus.d_req;
`ifdef MEM_ARB_FAIR_EN
      fair_cnt_d  = fair_cnt_q;
      // Fetch has waited through two data grants: let it through this time.
      if (bus.d_req && bus.if_req && (fair_cnt_q == 2'd2)) begin
         grant_d = 1'b0;
      end
`endif

      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d     = SERVE_D;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.d_we;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
`ifdef MEM_ARB_FAIR_EN
               // Only data grants that made fetch wait count toward starvation.
               if (bus.if_req) begin
                  fair_cnt_d = (fair_cnt_q == 2'd2) ? 2'd2 : fair_cnt_q + 2'd1;
               end else begin
                  fair_cnt_d = 2'd0;
               end
`endif
            end else if (bus.if_req) begin
               // Fetch never writes; write data bus keeps its last value.
               state_d    = SERVE_I;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = bus.if_addr;
`ifdef MEM_ARB_FAIR_EN
               fair_cnt_d = 2'd0;
`endif
            end
         end
         SERVE_D, SERVE_I: begin
            if (bus.mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
`ifdef MEM_ARB_FAIR_EN
         fair_cnt_q  <= 2'd0;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_FAIR_EN
         fair_cnt_q  <= fair_cnt_d;
`endif
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = (state_q != IDLE);

   // Ready is qualified by state, so a stray ack in IDLE produces nothing and
   // the two ready pulses can never coincide.
   assign bus.if_ready  = (state_q == SERVE_I) && bus.mem_ack;
   assign bus.d_ready   = (state_q == SERVE_D) && bus.mem_ack;
   assign bus.if_rdata  = bus.mem_rdata;
   assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus fairness and reset-abort sequences.
// Latency: inputs driven on the falling edge, outputs checked 1 ns later.
// Backpressure: memory model acks as directed by the table or one cycle after mem_req.
module tb_mem_arbiter;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        mem_ack;
      logic [31:0] mem_rdata;
      logic        e_mem_req;
      logic        e_mem_we;
      logic [31:0] e_mem_addr;
      logic [31:0] e_mem_wdata;
      logic        e_busy;
      logic        e_if_ready;
      logic        e_d_ready;
      logic [31:0] e_rdata;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic ifr, input logic [31:0] ifa,
      input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
      input logic ack, input logic [31:0] rd,
      input logic emr, input logic emw, input logic [31:0] ema, input logic [31:0] emd,
      input logic eb, input logic eir, input logic edr, input logic [31:0] erd);
      vec_t v;
      v.if_req = ifr;  v.if_addr = ifa;
      v.d_req = dr;    v.d_we = dwe;   v.d_addr = da;  v.d_wdata = dwd;
      v.mem_ack = ack; v.mem_rdata = rd;
      v.e_mem_req = emr; v.e_mem_we = emw; v.e_mem_addr = ema; v.e_mem_wdata = emd;
      v.e_busy = eb;   v.e_if_ready = eir; v.e_d_ready = edr; v.e_rdata = erd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.if_req = 1'b0; bus.if_addr = 32'd0;
      bus.d_req = 1'b0;  bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string      exp_order;
      logic [7:0] grants [6];
      int         ngrant;
      int         overlap;

      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      drive_idle();

      //        ifr ifa          dr dwe da           dwd          ack rd           | mreq mwe maddr        mwdata       busy ir dr rdata
      vecs[0]  = mk(0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 32'h0,        0, 0, 32'h0,    32'h0,       0, 0, 0, 32'h0);
      vecs[1]  = mk(1, 32'h100,   0, 0, 32'h0,    32'h0,       0, 32'h0,        0, 0, 32'h0,    32'h0,       0, 0, 0, 32'h0);
      vecs[2]  = mk(1, 32'h100,   0, 0, 32'h0,    32'h0,       0, 32'h0,        1, 0, 32'h100,  32'h0,       1, 0, 0, 32'h0);
      vecs[3]  = mk(1, 32'h100,   0, 0, 32'h0,    32'h0,       1, 32'h00500093, 1, 0, 32'h100,  32'h0,       1, 1, 0, 32'h00500093);
      vecs[4]  = mk(0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 32'h0,        0, 0, 32'h100,  32'h0,       0, 0, 0, 32'h0);
      vecs[5]  = mk(0, 32'h0,     1, 1, 32'h1000, 32'hDEADBEEF, 0, 32'h0,       0, 0, 32'h100,  32'h0,       0, 0, 0, 32'h0);
      vecs[6]  = mk(0, 32'h0,     1, 1, 32'h1000, 32'hDEADBEEF, 0, 32'h0,       1, 1, 32'h1000, 32'hDEADBEEF, 1, 0, 0, 32'h0);
      vecs[7]  = mk(0, 32'h0,     1, 1, 32'h1000, 32'hDEADBEEF, 0, 32'h0,       1, 1, 32'h1000, 32'hDEADBEEF, 1, 0, 0, 32'h0);
      vecs[8]  = mk(0, 32'h0,     1, 1, 32'h1000, 32'hDEADBEEF, 0, 32'h0,       1, 1, 32'h1000, 32'hDEADBEEF, 1, 0, 0, 32'h0);
      vecs[9]  = mk(0, 32'h0,     1, 1, 32'h1000, 32'hDEADBEEF, 1, 32'h5555AAAA, 1, 1, 32'h1000, 32'hDEADBEEF, 1, 0, 1, 32'h0);
      vecs[10] = mk(0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 32'h0,        0, 1, 32'h1000, 32'hDEADBEEF, 0, 0, 0, 32'h0);
      vecs[11] = mk(0, 32'h0,     0, 0, 32'h0,    32'h0,       1, 32'hFFFFFFFF, 0, 1, 32'h1000, 32'hDEADBEEF, 0, 0, 0, 32'h0);
      vecs[12] = mk(0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 32'h0,        0, 1, 32'h1000, 32'hDEADBEEF, 0, 0, 0, 32'h0);
      vecs[13] = mk(1, 32'h200,   1, 0, 32'h2000, 32'h11,      0, 32'h0,        0, 1, 32'h1000, 32'hDEADBEEF, 0, 0, 0, 32'h0);
      vecs[14] = mk(1, 32'h200,   1, 0, 32'h2000, 32'h11,      1, 32'hCAFEF00D, 1, 0, 32'h2000, 32'h11,      1, 0, 1, 32'hCAFEF00D);
      vecs[15] = mk(1, 32'h200,   0, 0, 32'h0,    32'h0,       0, 32'h0,        0, 0, 32'h2000, 32'h11,      0, 0, 0, 32'h0);
      vecs[16] = mk(1, 32'h200,   0, 0, 32'h0,    32'h0,       1, 32'h12345678, 1, 0, 32'h200,  32'h11,      1, 1, 0, 32'h12345678);
      vecs[17] = mk(0, 32'h0,     0, 0, 32'h0,    32'h0,       0, 32'h0,        0, 0, 32'h200,  32'h11,      0, 0, 0, 32'h0);

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
      chk("rst_mem_we",    {31'd0, bus.mem_we},  32'd0);
      chk("rst_mem_addr",  bus.mem_addr,         32'd0);
      chk("rst_mem_wdata", bus.mem_wdata,        32'd0);
      chk("rst_busy",      {31'd0, bus.busy},    32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Vector table: single fetch, 3-cycle store, stray ack, collision
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         bus.if_req    = vecs[i].if_req;
         bus.if_addr   = vecs[i].if_addr;
         bus.d_req     = vecs[i].d_req;
         bus.d_we      = vecs[i].d_we;
         bus.d_addr    = vecs[i].d_addr;
         bus.d_wdata   = vecs[i].d_wdata;
         bus.mem_ack   = vecs[i].mem_ack;
         bus.mem_rdata = vecs[i].mem_rdata;
         #1;
         chk($sformatf("v%0d_mem_req", i),   {31'd0, bus.mem_req},  {31'd0, vecs[i].e_mem_req});
         chk($sformatf("v%0d_mem_we", i),    {31'd0, bus.mem_we},   {31'd0, vecs[i].e_mem_we});
         chk($sformatf("v%0d_mem_addr", i),  bus.mem_addr,          vecs[i].e_mem_addr);
         chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata,         vecs[i].e_mem_wdata);
         chk($sformatf("v%0d_busy", i),      {31'd0, bus.busy},     {31'd0, vecs[i].e_busy});
         chk($sformatf("v%0d_if_ready", i),  {31'd0, bus.if_ready}, {31'd0, vecs[i].e_if_ready});
         chk($sformatf("v%0d_d_ready", i),   {31'd0, bus.d_ready},  {31'd0, vecs[i].e_d_ready});
         if (vecs[i].e_if_ready)
            chk($sformatf("v%0d_if_rdata", i), bus.if_rdata, vecs[i].e_rdata);
         if (vecs[i].e_d_ready && !vecs[i].d_we)
            chk($sformatf("v%0d_d_rdata", i), bus.d_rdata, vecs[i].e_rdata);
      end

      // Fairness: both requests held high, memory acks the cycle after mem_req rises
`ifdef MEM_ARB_FAIR_EN
      exp_order = "DDIDDI";
`else
      exp_order = "DDDDDD";
`endif
      ngrant  = 0;
      overlap = 0;
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'h300;
      bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000; bus.d_wdata = 32'h0;
      for (int c = 0; c < 80 && ngrant < 6; c++) begin
         @(negedge clk);
         bus.mem_ack   = bus.mem_req;
         bus.mem_rdata = 32'h77;
         #1;
         if (bus.if_ready && bus.d_ready) overlap++;
         if (bus.d_ready)  begin grants[ngrant] = "D"; ngrant++; end
         else if (bus.if_ready) begin grants[ngrant] = "I"; ngrant++; end
      end
      chk("fair_grant_count", ngrant, 6);
      chk("fair_no_overlap",  overlap, 0);
      for (int g = 0; g < 6; g++) begin
         if (g < ngrant)
            chk($sformatf("fair_grant%0d", g), {24'd0, grants[g]}, {24'd0, exp_order[g]});
      end
      @(negedge clk);
      drive_idle();
      repeat (2) @(negedge clk);

      // Reset in the middle of a data access, then a late ack
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h4000; bus.d_wdata = 32'hA5A5A5A5;
      @(negedge clk);
      #1;
      chk("rma_busy_before", {31'd0, bus.busy},    32'd1);
      chk("rma_mreq_before", {31'd0, bus.mem_req}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rma_mreq_in_rst",  {31'd0, bus.mem_req}, 32'd0);
      chk("rma_busy_in_rst",  {31'd0, bus.busy},    32'd0);
      chk("rma_dready_in_rst",{31'd0, bus.d_ready}, 32'd0);
      chk("rma_addr_in_rst",  bus.mem_addr,         32'd0);
      chk("rma_wdata_in_rst", bus.mem_wdata,        32'd0);
      bus.d_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ack = 1'b1;
      #1;
      chk("rma_late_ack_dready", {31'd0, bus.d_ready}, 32'd0);
      chk("rma_late_ack_busy",   {31'd0, bus.busy},    32'd0);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      chk("rma_after_busy", {31'd0, bus.busy},    32'd0);
      chk("rma_after_mreq", {31'd0, bus.mem_req}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose the following ports, one per line:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  instruction fetch request
- if_addr  in  32  fetch byte address
- if_ready  out  1  fetch complete, one-cycle pulse
- if_rdata  out  32  fetch data, valid with if_ready
- d_req  in  1  data request (MemRead or MemWrite)
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_ready  out  1  data access complete, one-cycle pulse
- d_rdata  out  32  load data, valid with d_ready
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory done, one-cycle pulse
- mem_rdata  in  32  memory read data, valid with mem_ack
- busy  out  1  high in any state other than IDLE
REQ-002 There SHALL be one clock; reset SHALL be asynchronous and active-low.

Function
REQ-003 The block SHALL share one single-port memory between the fetch requester and the data requester using three FSM states: IDLE, SERVE_D and SERVE_I.
REQ-004 In IDLE, if d_req is high and the fairness rule (REQ-012) does not select fetch, the block SHALL go to SERVE_D and register d_we, d_addr and d_wdata onto mem_we, mem_addr and mem_wdata.
REQ-005 In IDLE, if if_req is high and the data requester is not granted, the block SHALL go to SERVE_I and register mem_we=0 and mem_addr=if_addr; mem_wdata SHALL hold its previous value.
REQ-006 In IDLE, with no request pending, the block SHALL stay in IDLE with mem_req=0.
REQ-007 mem_req SHALL be high throughout SERVE_D and SERVE_I, and mem_addr, mem_we and mem_wdata SHALL stay stable until mem_ack is sampled high.
REQ-008 In SERVE_x, when mem_ack=1, x_ready SHALL be driven combinationally high in that same cycle, x_rdata SHALL equal mem_rdata, and the FSM SHALL return to IDLE on the next edge.
- Minimum latency: request sampled at edge N, mem_req high at N+1, earliest ready in cycle N+1.
REQ-009 A requester SHALL hold req and its operands stable until it sees its ready pulse; the block SHALL sample a new request no earlier than the edge after ready.
REQ-010 if_ready and d_ready SHALL never be high in the same cycle; neither SHALL pulse outside its own SERVE state.
REQ-011 mem_ack received in IDLE SHALL be ignored and SHALL cause no state change. d_rdata is don't-care for stores, but d_ready SHALL still pulse.
REQ-012 Arbitration default: when both requests are high in IDLE, data SHALL win (strict priority).
REQ-013 busy SHALL equal (state != IDLE).

Reset
REQ-014 When rst_n=0, the block SHALL asynchronously force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, d_ready=0, busy=0 and the fairness counter to 0.
REQ-015 Reset during SERVE_x SHALL abandon the in-flight access with no ready pulse; a late mem_ack after reset SHALL be ignored per REQ-011.
REQ-016 The first request SHALL be sampled at the first rising edge after rst_n deasserts.

Configuration
REQ-017 With macro MEM_ARB_FAIR_EN defined, the block SHALL keep a 2-bit counter of consecutive data grants made while if_req was high.
- When the counter equals 2 and both requests are pending in IDLE, fetch SHALL be granted and the counter SHALL clear.
- Any fetch grant SHALL clear the counter; a data grant with if_req low SHALL clear it.
REQ-018 Without MEM_ARB_FAIR_EN, the counter SHALL be absent and strict data priority (REQ-012) SHALL apply.

Verification
REQ-019 Bench scenarios, one line each:
- Single fetch: if_req=1, if_addr=0x100; memory acks 1 cycle after mem_req with 0x00500093 -> mem_addr=0x100, mem_we=0, if_ready pulses once with if_rdata=0x00500093, busy falls the next cycle.
- Store: d_req=1, d_we=1, d_addr=0x1000, d_wdata=0xDEADBEEF; ack after 3 cycles -> mem_we=1, mem_wdata=0xDEADBEEF held stable 3 cycles, one d_ready pulse.
- Collision: if_req and d_req rise in the same cycle -> data served first, fetch served in the next SERVE_I, ready pulses never overlap.
- Fairness (MEM_ARB_FAIR_EN): if_req high with d_req high continuously -> grant order D, D, I, D, D, I; without the macro -> D only, fetch starves.
- Reset mid-access: rst_n=0 in SERVE_D before mem_ack, then mem_ack after release -> mem_req=0 immediately, no d_ready, state IDLE.
- Stray ack: mem_ack=1 in IDLE with no requests -> no ready pulse, busy stays 0.
